// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings and helpers for the data-memory responder.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package dmem_ctrl_pkg;

   typedef enum logic [2:0] {
      DT_NONE  = 3'b000,
      DT_BYTE  = 3'b001,
      DT_HALF  = 3'b010,
      DT_WORD  = 3'b011,
      DT_UBYTE = 3'b101,
      DT_UHALF = 3'b110
   } data_type_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SPLIT_LD = 2'd1,
      ST_SPLIT_ST = 2'd2
   } state_e;

   localparam logic [31:0] mem_addr_zero = 32'h0000_0000;
   localparam logic [31:0] data_zero     = 32'h0000_0000;

   // Only the five real access types start an SRAM access.
   function automatic logic type_valid(input logic [2:0] t);
      case (t)
         DT_BYTE, DT_HALF, DT_WORD, DT_UBYTE, DT_UHALF: type_valid = 1'b1;
         default:                                       type_valid = 1'b0;
      endcase
   endfunction

   // Access size in bytes; 0 for types that never reach the SRAM.
   function automatic logic [2:0] type_size(input logic [2:0] t);
      case (t)
         DT_BYTE, DT_UBYTE: type_size = 3'd1;
         DT_HALF, DT_UHALF: type_size = 3'd2;
         DT_WORD:           type_size = 3'd4;
         default:           type_size = 3'd0;
      endcase
   endfunction

   // Right-aligned byte mask covering the access size.
   function automatic logic [3:0] size_mask(input logic [2:0] t);
      case (t)
         DT_BYTE, DT_UBYTE: size_mask = 4'b0001;
         DT_HALF, DT_UHALF: size_mask = 4'b0011;
         DT_WORD:           size_mask = 4'b1111;
         default:           size_mask = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatter: store lane mask/data across a two-word window, load extract + extend.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the results are used.
module dmem_lane_fmt
   import dmem_ctrl_pkg::*;
(
   input  logic [2:0]  st_type,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [3:0]  we_lo,
   output logic [3:0]  we_hi,
   output logic [31:0] wdata_lo,
   output logic [31:0] wdata_hi,
   input  logic [2:0]  ld_type,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_word_lo,
   input  logic [31:0] ld_word_hi,
   output logic [31:0] ld_data
);

   logic [3:0]  st_mask;
   logic [7:0]  st_mask_wide;
   logic [31:0] st_data_m;
   logic [63:0] st_data_wide;
   logic [31:0] ld_shift;

   // Store side: mask unused bytes, then shift lanes into the low/high word pair.
   always_comb begin
      st_mask   = size_mask(st_type);
      st_data_m = data_zero;
      for (int i = 0; i < 4; i++) begin
         st_data_m[8*i +: 8] = st_mask[i] ? st_data[8*i +: 8] : 8'h00;
      end
      st_mask_wide = {4'b0000, st_mask} << st_off;
      st_data_wide = {data_zero, st_data_m} << {st_off, 3'b000};
      we_lo        = st_mask_wide[3:0];
      we_hi        = st_mask_wide[7:4];
      wdata_lo     = st_data_wide[31:0];
      wdata_hi     = st_data_wide[63:32];
   end

   // Load side: shift the two-word window down by the offset and extend to 32 bits.
   always_comb begin
      ld_shift = 32'({ld_word_hi, ld_word_lo} >> {ld_off, 3'b000});
      case (ld_type)
         DT_BYTE:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
         DT_UBYTE: ld_data = {24'h000000, ld_shift[7:0]};
         DT_HALF:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
         DT_UHALF: ld_data = {16'h0000, ld_shift[15:0]};
         DT_WORD:  ld_data = ld_shift;
         default:  ld_data = data_zero;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder: issues load/store beats to a word SRAM, returns extended load data.
// Latency: aligned load result at T+1, word-crossing load at T+2; stores produce no result.
// Backpressure: mem_hold_o stalls upstream for one cycle while a crossing access issues beat 2.
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int ADDR_W         = 12,
   parameter bit MISALIGN_SPLIT = 1'b1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r_mem_enable_i,
   input  logic [31:0]       r_mem_addr_i,
   input  logic              w_mem_enable_i,
   input  logic [31:0]       w_mem_addr_i,
   input  logic [31:0]       w_mem_data_i,
   input  logic [2:0]        data_type_i,
   input  logic [4:0]        w_reg_addr_i,
   output logic              mem_hold_o,
   output logic              misalign_o,
   output logic              mem_w_reg_enable_o,
   output logic [4:0]        w_reg_addr_o,
   output logic [31:0]       r_mem_data_o,
   output logic              ram_en_o,
   output logic [3:0]        ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [31:0]       ram_wdata_o,
   input  logic [31:0]       ram_rdata_i
);

   // request decode
   logic              is_store;
   logic              req_vld;
   logic              crossing;
   logic [31:0]       req_addr;
   logic [1:0]        req_off;
   logic [ADDR_W-1:0] req_word;
   logic              unused_addr_hi;

   // lane formatter results
   logic [3:0]  we_lo, we_hi;
   logic [31:0] wdata_lo, wdata_hi, ld_data;
   logic [31:0] ld_word_lo, ld_word_hi;

   // FSM and control strobes
   state_e state_q, state_d;
   logic   issue_ld;
   logic   start_split;
   logic   drop;

   // beat-2 capture
   logic [ADDR_W-1:0] cap_addr_q;
   logic [3:0]        cap_we_q;
   logic [31:0]       cap_wdata_q;
   logic [2:0]        cap_type_q;
   logic [4:0]        cap_reg_q;
   logic [1:0]        cap_off_q;

   // response metadata, kept apart from the issue path so a result can overlap a new request
   logic        rsp_vld_q;
   logic        rsp_split_q;
   logic [2:0]  rsp_type_q;
   logic [1:0]  rsp_off_q;
   logic [4:0]  rsp_reg_q;
   logic [31:0] buf_q;
   logic        misalign_q;

   // Stores win over loads; rst_n gates the request so outputs drop the instant reset asserts.
   assign is_store       = w_mem_enable_i;
   assign req_addr       = is_store ? w_mem_addr_i : r_mem_addr_i;
   assign req_off        = req_addr[1:0];
   assign req_word       = req_addr[ADDR_W+1:2];
   assign req_vld        = rst_n && (w_mem_enable_i || r_mem_enable_i) && type_valid(data_type_i);
   assign crossing       = ({1'b0, req_off} + type_size(data_type_i)) > 3'd4;
   assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

   // Split loads put word N in the buffer (low) and word N+1 arrives live (high).
   assign ld_word_lo = rsp_split_q ? buf_q       : ram_rdata_i;
   assign ld_word_hi = rsp_split_q ? ram_rdata_i : data_zero;

   dmem_lane_fmt u_fmt (
      .st_type    (data_type_i),
      .st_off     (req_off),
      .st_data    (w_mem_data_i),
      .we_lo      (we_lo),
      .we_hi      (we_hi),
      .wdata_lo   (wdata_lo),
      .wdata_hi   (wdata_hi),
      .ld_type    (rsp_type_q),
      .ld_off     (rsp_off_q),
      .ld_word_lo (ld_word_lo),
      .ld_word_hi (ld_word_hi),
      .ld_data    (ld_data)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next state and SRAM beat selection: beat 1 / aligned beats from inputs, beat 2 from captures.
   always_comb begin
      state_d     = state_q;
      mem_hold_o  = 1'b0;
      ram_en_o    = 1'b0;
      ram_we_o    = 4'b0000;
      ram_addr_o  = mem_addr_zero[ADDR_W-1:0];
      ram_wdata_o = data_zero;
      issue_ld    = 1'b0;
      start_split = 1'b0;
      drop        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_vld) begin
               if (!crossing || MISALIGN_SPLIT) begin
                  ram_en_o   = 1'b1;
                  ram_addr_o = req_word;
                  if (is_store) begin
                     ram_we_o    = we_lo;
                     ram_wdata_o = wdata_lo;
                  end
                  if (crossing) begin
                     mem_hold_o  = 1'b1;
                     start_split = 1'b1;
                     state_d     = is_store ? ST_SPLIT_ST : ST_SPLIT_LD;
                  end else begin
                     issue_ld = !is_store;
                  end
               end else begin
                  drop = 1'b1;
               end
            end
         end
         ST_SPLIT_LD: begin
            ram_en_o   = 1'b1;
            ram_addr_o = cap_addr_q;
            state_d    = ST_IDLE;
         end
         ST_SPLIT_ST: begin
            ram_en_o    = 1'b1;
            ram_addr_o  = cap_addr_q;
            ram_we_o    = cap_we_q;
            ram_wdata_o = cap_wdata_q;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Capture beat-2 address (next word, wrapping), remaining lanes and load metadata.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_addr_q  <= '0;
         cap_we_q    <= 4'b0000;
         cap_wdata_q <= data_zero;
         cap_type_q  <= DT_NONE;
         cap_reg_q   <= 5'd0;
         cap_off_q   <= 2'd0;
      end else if (start_split) begin
         cap_addr_q  <= req_word + ADDR_W'(1);
         cap_we_q    <= we_hi;
         cap_wdata_q <= wdata_hi;
         cap_type_q  <= data_type_i;
         cap_reg_q   <= w_reg_addr_i;
         cap_off_q   <= req_off;
      end
   end

   // Response scheduling: one-cycle pulse after the final load beat; beat-1 data buffered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_vld_q   <= 1'b0;
         rsp_split_q <= 1'b0;
         rsp_type_q  <= DT_NONE;
         rsp_off_q   <= 2'd0;
         rsp_reg_q   <= 5'd0;
         buf_q       <= data_zero;
         misalign_q  <= 1'b0;
      end else begin
         rsp_vld_q  <= issue_ld || (state_q == ST_SPLIT_LD);
         misalign_q <= drop;
         if (issue_ld) begin
            rsp_split_q <= 1'b0;
            rsp_type_q  <= data_type_i;
            rsp_off_q   <= req_off;
            rsp_reg_q   <= w_reg_addr_i;
         end else if (state_q == ST_SPLIT_LD) begin
            rsp_split_q <= 1'b1;
            rsp_type_q  <= cap_type_q;
            rsp_off_q   <= cap_off_q;
            rsp_reg_q   <= cap_reg_q;
            buf_q       <= ram_rdata_i;
         end
      end
   end

   assign mem_w_reg_enable_o = rsp_vld_q;
   assign w_reg_addr_o       = rsp_vld_q ? rsp_reg_q : 5'd0;
   assign r_mem_data_o       = rsp_vld_q ? ld_data : data_zero;
   assign misalign_o         = misalign_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed vector table plus split, wrap, reset and no-split sequences.
// Latency: checks issue outputs in the request cycle and load results one or two cycles later.
// Backpressure: honours mem_hold_o by holding the request for the extra split cycle.
module tb_dmem_ctrl;
   import dmem_ctrl_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        r_en, w_en;
   logic [31:0] r_addr, w_addr, w_data;
   logic [2:0]  dtype;
   logic [4:0]  rd;

   logic        hold, misalign, wren;
   logic [4:0]  wrd;
   logic [31:0] rdata;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [11:0] ram_addr;
   logic [31:0] ram_wdata, ram_rdata;

   logic        n_hold, n_misalign, n_wren;
   logic [4:0]  n_wrd;
   logic [31:0] n_rdata;
   logic        n_ram_en;
   logic [3:0]  n_ram_we;
   logic [11:0] n_ram_addr;
   logic [31:0] n_ram_wdata;
   logic [31:0] n_ram_rdata;
   assign n_ram_rdata = 32'h0;

   int n_checks = 0;
   int n_pass   = 0;

   dmem_ctrl #(.ADDR_W(12), .MISALIGN_SPLIT(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .r_mem_enable_i(r_en), .r_mem_addr_i(r_addr),
      .w_mem_enable_i(w_en), .w_mem_addr_i(w_addr), .w_mem_data_i(w_data),
      .data_type_i(dtype), .w_reg_addr_i(rd),
      .mem_hold_o(hold), .misalign_o(misalign),
      .mem_w_reg_enable_o(wren), .w_reg_addr_o(wrd), .r_mem_data_o(rdata),
      .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
      .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
   );

   dmem_ctrl #(.ADDR_W(12), .MISALIGN_SPLIT(1'b0)) dut_nosplit (
      .clk(clk), .rst_n(rst_n),
      .r_mem_enable_i(r_en), .r_mem_addr_i(r_addr),
      .w_mem_enable_i(w_en), .w_mem_addr_i(w_addr), .w_mem_data_i(w_data),
      .data_type_i(dtype), .w_reg_addr_i(rd),
      .mem_hold_o(n_hold), .misalign_o(n_misalign),
      .mem_w_reg_enable_o(n_wren), .w_reg_addr_o(n_wrd), .r_mem_data_o(n_rdata),
      .ram_en_o(n_ram_en), .ram_we_o(n_ram_we), .ram_addr_o(n_ram_addr),
      .ram_wdata_o(n_ram_wdata), .ram_rdata_i(n_ram_rdata)
   );

   // Single-port synchronous SRAM, read-first, byte write enables.
   logic [31:0] mem [0:4095];
   logic        mem_clr;
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
         ram_rdata <= 32'h0;
      end else if (ram_en) begin
         for (int i = 0; i < 4; i++)
            if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
         ram_rdata <= mem[ram_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic idle();
      r_en = 1'b0; w_en = 1'b0; r_addr = 32'h0; w_addr = 32'h0;
      w_data = 32'h0; dtype = DT_NONE; rd = 5'd0;
   endtask

   task automatic drive(input logic w, input logic r, input logic [31:0] wa, input logic [31:0] ra,
                        input logic [31:0] wd, input logic [2:0] dt, input logic [4:0] rg);
      w_en = w; r_en = r; w_addr = wa; r_addr = ra; w_data = wd; dtype = dt; rd = rg;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".hold"},  32'(hold),      32'h0);
      chk({tag, ".en"},    32'(ram_en),    32'h0);
      chk({tag, ".we"},    32'(ram_we),    32'h0);
      chk({tag, ".addr"},  32'(ram_addr),  32'h0);
      chk({tag, ".wdata"}, ram_wdata,      32'h0);
      chk({tag, ".pulse"}, 32'(wren),      32'h0);
      chk({tag, ".rd"},    32'(wrd),       32'h0);
      chk({tag, ".data"},  rdata,          32'h0);
      chk({tag, ".mis"},   32'(misalign),  32'h0);
      chk({tag, ".n_en"},  32'(n_ram_en),  32'h0);
      chk({tag, ".n_mis"}, 32'(n_misalign), 32'h0);
   endtask

   typedef struct {
      logic        w;
      logic        r;
      logic [31:0] wa;
      logic [31:0] ra;
      logic [31:0] wd;
      logic [2:0]  dt;
      logic [4:0]  rg;
      logic        en;
      logic [3:0]  we;
      logic [11:0] addr;
      logic [31:0] ewd;
      logic        pulse;
      logic [31:0] edata;
      logic [4:0]  erd;
   } vec_t;

   function automatic vec_t mk(logic w, logic r, logic [31:0] wa, logic [31:0] ra, logic [31:0] wd,
                               logic [2:0] dt, logic [4:0] rg, logic en, logic [3:0] we,
                               logic [11:0] addr, logic [31:0] ewd, logic pulse,
                               logic [31:0] edata, logic [4:0] erd);
      vec_t v;
      v.w = w; v.r = r; v.wa = wa; v.ra = ra; v.wd = wd; v.dt = dt; v.rg = rg;
      v.en = en; v.we = we; v.addr = addr; v.ewd = ewd;
      v.pulse = pulse; v.edata = edata; v.erd = erd;
      return v;
   endfunction

   // One non-crossing access: issue outputs at T, result (or silence) at T+1.
   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      drive(v.w, v.r, v.wa, v.ra, v.wd, v.dt, v.rg);
      #1;
      chk({tag, ".hold"},  32'(hold),     32'h0);
      chk({tag, ".en"},    32'(ram_en),   32'(v.en));
      chk({tag, ".we"},    32'(ram_we),   32'(v.we));
      chk({tag, ".addr"},  32'(ram_addr), 32'(v.addr));
      chk({tag, ".wdata"}, ram_wdata,     v.ewd);
      @(negedge clk);
      idle();
      #1;
      chk({tag, ".pulse"}, 32'(wren),     32'(v.pulse));
      chk({tag, ".rd"},    32'(wrd),      32'(v.erd));
      chk({tag, ".data"},  rdata,         v.edata);
      chk({tag, ".mis"},   32'(misalign), 32'h0);
   endtask

   // Word-crossing store: beat 1 with hold, beat 2 next cycle, never a result pulse.
   task automatic split_store(input logic [31:0] a, input logic [31:0] d, input string tag,
                              input logic [11:0] a1, input logic [3:0] we1, input logic [31:0] wd1,
                              input logic [11:0] a2, input logic [3:0] we2, input logic [31:0] wd2);
      @(negedge clk);
      drive(1'b1, 1'b0, a, 32'h0, d, DT_HALF, 5'd0);
      #1;
      chk({tag, ".b1.hold"},  32'(hold),     32'h1);
      chk({tag, ".b1.en"},    32'(ram_en),   32'h1);
      chk({tag, ".b1.addr"},  32'(ram_addr), 32'(a1));
      chk({tag, ".b1.we"},    32'(ram_we),   32'(we1));
      chk({tag, ".b1.wdata"}, ram_wdata,     wd1);
      @(negedge clk);
      #1;
      chk({tag, ".b2.hold"},  32'(hold),     32'h0);
      chk({tag, ".b2.en"},    32'(ram_en),   32'h1);
      chk({tag, ".b2.addr"},  32'(ram_addr), 32'(a2));
      chk({tag, ".b2.we"},    32'(ram_we),   32'(we2));
      chk({tag, ".b2.wdata"}, ram_wdata,     wd2);
      @(negedge clk);
      idle();
      #1;
      chk({tag, ".pulse"},    32'(wren),     32'h0);
      chk({tag, ".en_after"}, 32'(ram_en),   32'h0);
   endtask

   vec_t tv[$];

   initial begin
      rst_n   = 1'b0;
      mem_clr = 1'b1;
      idle();
      #1;
      chk_zero("reset");
      repeat (2) @(negedge clk);
      mem_clr = 1'b0;
      rst_n   = 1'b1;

      //         w     r     w_addr        r_addr        w_data        type      rd     en    we       addr    wdata         pulse data          rd
      tv.push_back(mk(1'b1, 1'b0, 32'h100,  32'h0,    32'hDEADBEEF, DT_WORD,  5'd0,  1'b1, 4'b1111, 12'h040, 32'hDEADBEEF, 1'b0, 32'h0,        5'd0));
      tv.push_back(mk(1'b0, 1'b1, 32'h0,    32'h100,  32'h0,        DT_WORD,  5'd5,  1'b1, 4'b0000, 12'h040, 32'h0,        1'b1, 32'hDEADBEEF, 5'd5));
      tv.push_back(mk(1'b1, 1'b0, 32'h103,  32'h0,    32'h00000080, DT_BYTE,  5'd0,  1'b1, 4'b1000, 12'h040, 32'h80000000, 1'b0, 32'h0,        5'd0));
      tv.push_back(mk(1'b0, 1'b1, 32'h0,    32'h103,  32'h0,        DT_BYTE,  5'd6,  1'b1, 4'b0000, 12'h040, 32'h0,        1'b1, 32'hFFFFFF80, 5'd6));
      tv.push_back(mk(1'b0, 1'b1, 32'h0,    32'h103,  32'h0,        DT_UBYTE, 5'd7,  1'b1, 4'b0000, 12'h040, 32'h0,        1'b1, 32'h00000080, 5'd7));
      tv.push_back(mk(1'b1, 1'b0, 32'h0,    32'h0,    32'hFFFF8001, DT_HALF,  5'd0,  1'b1, 4'b0011, 12'h000, 32'h00008001, 1'b0, 32'h0,        5'd0));
      tv.push_back(mk(1'b0, 1'b1, 32'h0,    32'h0,    32'h0,        DT_HALF,  5'd1,  1'b1, 4'b0000, 12'h000, 32'h0,        1'b1, 32'hFFFF8001, 5'd1));
      tv.push_back(mk(1'b0, 1'b1, 32'h0,    32'h0,    32'h0,        DT_UHALF, 5'd31, 1'b1, 4'b0000, 12'h000, 32'h0,        1'b1, 32'h00008001, 5'd31));
      tv.push_back(mk(1'b1, 1'b1, 32'h4,    32'h100,  32'h12345678, DT_WORD,  5'd3,  1'b1, 4'b1111, 12'h001, 32'h12345678, 1'b0, 32'h0,        5'd0));
      tv.push_back(mk(1'b0, 1'b1, 32'h0,    32'h100,  32'h0,        DT_NONE,  5'd4,  1'b0, 4'b0000, 12'h000, 32'h0,        1'b0, 32'h0,        5'd0));
      tv.push_back(mk(1'b0, 1'b1, 32'h0,    32'h4,    32'h0,        DT_WORD,  5'd0,  1'b1, 4'b0000, 12'h001, 32'h0,        1'b1, 32'h12345678, 5'd0));
      tv.push_back(mk(1'b0, 1'b1, 32'h0,    32'h4004, 32'h0,        DT_WORD,  5'd2,  1'b1, 4'b0000, 12'h001, 32'h0,        1'b1, 32'h12345678, 5'd2));
      tv.push_back(mk(1'b0, 1'b1, 32'h0,    32'h6,    32'h0,        DT_UHALF, 5'd3,  1'b1, 4'b0000, 12'h001, 32'h0,        1'b1, 32'h00001234, 5'd3));
      tv.push_back(mk(1'b0, 1'b1, 32'h0,    32'h1,    32'h0,        DT_BYTE,  5'd8,  1'b1, 4'b0000, 12'h000, 32'h0,        1'b1, 32'hFFFFFF80, 5'd8));
      tv.push_back(mk(1'b0, 1'b1, 32'h0,    32'h100,  32'h0,        3'b111,   5'd9,  1'b0, 4'b0000, 12'h000, 32'h0,        1'b0, 32'h0,        5'd0));
      tv.push_back(mk(1'b0, 1'b0, 32'h100,  32'h100,  32'h0,        DT_WORD,  5'd9,  1'b0, 4'b0000, 12'h000, 32'h0,        1'b0, 32'h0,        5'd0));
      tv.push_back(mk(1'b1, 1'b0, 32'h100,  32'h0,    32'h44332211, DT_WORD,  5'd0,  1'b1, 4'b1111, 12'h040, 32'h44332211, 1'b0, 32'h0,        5'd0));
      tv.push_back(mk(1'b1, 1'b0, 32'h104,  32'h0,    32'h88776655, DT_WORD,  5'd0,  1'b1, 4'b1111, 12'h041, 32'h88776655, 1'b0, 32'h0,        5'd0));
      tv.push_back(mk(1'b1, 1'b0, 32'h3FFD, 32'h0,    32'h0000005A, DT_BYTE,  5'd0,  1'b1, 4'b0010, 12'hFFF, 32'h00005A00, 1'b0, 32'h0,        5'd0));

      for (int i = 0; i < tv.size(); i++) apply(tv[i], $sformatf("v%0d", i));

      // Crossing load lw @0x102: hold only at T, beats to 0x40 then 0x41, result at T+2.
      @(negedge clk);
      drive(1'b0, 1'b1, 32'h0, 32'h102, 32'h0, DT_WORD, 5'd9);
      #1;
      chk("sld.T.hold",   32'(hold),      32'h1);
      chk("sld.T.en",     32'(ram_en),    32'h1);
      chk("sld.T.addr",   32'(ram_addr),  32'h040);
      chk("sld.T.we",     32'(ram_we),    32'h0);
      chk("sld.T.n_en",   32'(n_ram_en),  32'h0);
      chk("sld.T.n_hold", 32'(n_hold),    32'h0);
      @(negedge clk);
      #1;
      chk("sld.T1.hold",  32'(hold),      32'h0);
      chk("sld.T1.en",    32'(ram_en),    32'h1);
      chk("sld.T1.addr",  32'(ram_addr),  32'h041);
      chk("sld.T1.pulse", 32'(wren),      32'h0);
      chk("sld.T1.n_mis", 32'(n_misalign), 32'h1);
      chk("sld.T1.n_en",  32'(n_ram_en),  32'h0);
      @(negedge clk);
      idle();
      #1;
      chk("sld.T2.pulse",   32'(wren),   32'h1);
      chk("sld.T2.data",    rdata,       32'h66554433);
      chk("sld.T2.rd",      32'(wrd),    32'h9);
      chk("sld.T2.n_pulse", 32'(n_wren), 32'h0);
      @(negedge clk);
      #1;
      chk("sld.T3.pulse",   32'(wren),   32'h0);
      chk("sld.T3.data",    rdata,       32'h0);
      chk("sld.T3.n_pulse", 32'(n_wren), 32'h0);

      // Crossing half store sh 0xABCD @0x107, then read both touched words back.
      split_store(32'h107, 32'h0000ABCD, "sst",
                  12'h041, 4'b1000, 32'hCD000000, 12'h042, 4'b0001, 32'h000000AB);
      apply(mk(1'b0, 1'b1, 32'h0, 32'h104, 32'h0, DT_WORD, 5'd10, 1'b1, 4'b0000, 12'h041,
               32'h0, 1'b1, 32'hCD776655, 5'd10), "sst.rd41");
      apply(mk(1'b0, 1'b1, 32'h0, 32'h108, 32'h0, DT_WORD, 5'd11, 1'b1, 4'b0000, 12'h042,
               32'h0, 1'b1, 32'h000000AB, 5'd11), "sst.rd42");

      // Crossing store at the top word wraps beat 2 to word 0.
      split_store(32'h3FFF, 32'h00001357, "wrap",
                  12'hFFF, 4'b1000, 32'h57000000, 12'h000, 4'b0001, 32'h00000013);
      apply(mk(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, DT_UBYTE, 5'd12, 1'b1, 4'b0000, 12'h000,
               32'h0, 1'b1, 32'h00000013, 5'd12), "wrap.rd0");

      // Reset while in SPLIT_LD: outputs clear at once, no result after release.
      @(negedge clk);
      drive(1'b0, 1'b1, 32'h0, 32'h102, 32'h0, DT_WORD, 5'd13);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_zero("rst_split");
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("rst_rel%0d.pulse", c), 32'(wren), 32'h0);
         chk($sformatf("rst_rel%0d.en", c),    32'(ram_en), 32'h0);
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
